counter8: RTL and testbench

- Free-running, parameterised binary counter for the 8-bit computer datapath (step/timing counter and program-counter style uses).
- Increments once per clock by default.
- Supports enable, synchronous parallel load, up/down direction and a programmable wrap value.
- Provides a terminal-count flag for cascading or sequencing.

---
 rtl/counter8.sv | 69 ++++++
 tb/tb_counter8.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter8.sv
// counter8 -- parameterised binary counter for the 8-bit computer datapath.
//
// It counts up or down once per clock when enabled. A synchronous parallel
// load takes priority over counting. The count wraps at a programmable
// maximum, MAX_VAL. tc flags the cycle whose next edge wraps, so counters
// can be cascaded or used to sequence other logic.
//
// Parameters:
//   WIDTH    bit width of the count and of the load value
//   MAX_VAL  highest count value, 1 <= MAX_VAL <= 2**WIDTH-1
//
// Ports:
//   clk    in   1      system clock, rising edge active
//   reset  in   1      asynchronous active-low reset; clears the count while low
//   en     in   1      count enable
//   load   in   1      synchronous parallel load (ignores en)
//   din    in   WIDTH  parallel load value, clamped to MAX_VAL
//   up     in   1      direction: 1 = up, 0 = down
//   value  out  WIDTH  current count (registered)
//   tc     out  1      terminal count, combinational from value and inputs
module counter8 #(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  output logic [WIDTH-1:0] value,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] value_q;

  // Next-state priority: load, then count up or down, then hold.
  // Wrap values come from MAX_V rather than natural overflow, so a reduced
  // modulus behaves exactly like the full-range case.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (din > MAX_V) ? MAX_V : din;
    end else if (en) begin
      if (up) begin
        value_d = (value_q == MAX_V) ? '0 : value_q + WIDTH'(1);
      end else begin
        value_d = (value_q == '0) ? MAX_V : value_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

  // tc is high only when the next enabled, non-load edge wraps.
  assign tc = en & ~load & ((up & (value_q == MAX_V)) | (~up & (value_q == '0)));

endmodule

// File: tb/tb_counter8.sv
module tb_counter8;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       load;
  logic [7:0] din;
  logic       up;
  logic [7:0] val_full;
  logic       tc_full;
  logic [7:0] val_mod;
  logic       tc_mod;

  int checks;
  int failures;

  // Reference state: plain integers, modular arithmetic.
  int md;
  int mm;
  localparam int M_FULL = 255;
  localparam int M_MOD  = 9;

  counter8 #(.WIDTH(8)) u_full (
    .clk(clk), .reset(reset_n), .en(en), .load(load), .din(din), .up(up),
    .value(val_full), .tc(tc_full)
  );

  counter8 #(.WIDTH(8), .MAX_VAL(9)) u_mod (
    .clk(clk), .reset(reset_n), .en(en), .load(load), .din(din), .up(up),
    .value(val_mod), .tc(tc_mod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] din;
    logic       up;
    logic       tc_f;
    logic       tc_m;
    logic [7:0] exp_f;
    logic [7:0] exp_m;
  } vec_t;

  vec_t tbl[15];

  function automatic int ref_next(int v, int m, bit r, bit e, bit l, int d, bit u);
    if (!r) return 0;
    if (l) return (d > m) ? m : d;
    if (!e) return v;
    if (u) return (v + 1) % (m + 1);
    return (v + m) % (m + 1);
  endfunction

  function automatic bit ref_tc(int v, int m, bit e, bit l, bit u);
    return e && !l && ((u && v == m) || (!u && v == 0));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, check tc, clock once, check value.
  task automatic step(input bit e, input bit l, input logic [7:0] d, input bit u);
    en = e; load = l; din = d; up = u;
    #1;
    chk("tc_full", tc_full, ref_tc(md, M_FULL, e, l, u));
    chk("tc_mod", tc_mod, ref_tc(mm, M_MOD, e, l, u));
    @(posedge clk);
    md = ref_next(md, M_FULL, reset_n, e, l, d, u);
    mm = ref_next(mm, M_MOD, reset_n, e, l, d, u);
    #1;
    chk("value_full", val_full, md);
    chk("value_mod", val_mod, mm);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    md = 0;
    mm = 0;
    reset_n = 1'b0;
    en = 1'b1; load = 1'b0; din = 8'h00; up = 1'b1;

    // Reset state before any clock edge.
    #2;
    chk("reset_value_full", val_full, 0);
    chk("reset_value_mod", val_mod, 0);
    chk("reset_tc_up", tc_full, 0);
    @(posedge clk);
    #1;
    chk("reset_hold_full", val_full, 0);
    reset_n = 1'b1;

    // Directed vectors starting from 0 with both counters.
    //         en    load  din    up    tc_f  tc_m  exp_f  exp_m
    tbl[0]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd1,   8'd1};
    tbl[1]  = '{1'b1, 1'b1, 8'h80,  1'b1, 1'b0, 1'b0, 8'h80,  8'd9};
    tbl[2]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 8'h81,  8'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'd5,   1'b1, 1'b0, 1'b0, 8'd5,   8'd5};
    tbl[4]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd5,   8'd5};
    tbl[5]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd5,   8'd5};
    tbl[6]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd6,   8'd6};
    tbl[7]  = '{1'b1, 1'b1, 8'd1,   1'b1, 1'b0, 1'b0, 8'd1,   8'd1};
    tbl[8]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   8'd0};
    tbl[9]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 8'd255, 8'd9};
    tbl[10] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd0,   8'd0};
    tbl[11] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   8'd0};
    tbl[12] = '{1'b0, 1'b1, 8'd20,  1'b1, 1'b0, 1'b0, 8'd20,  8'd9};
    tbl[13] = '{1'b1, 1'b1, 8'd9,   1'b1, 1'b0, 1'b0, 8'd9,   8'd9};
    tbl[14] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 8'd10,  8'd0};

    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; load = tbl[i].load; din = tbl[i].din; up = tbl[i].up;
      #1;
      chk("vec_tc_full", tc_full, tbl[i].tc_f);
      chk("vec_tc_mod", tc_mod, tbl[i].tc_m);
      @(posedge clk);
      #1;
      chk("vec_value_full", val_full, tbl[i].exp_f);
      chk("vec_value_mod", val_mod, tbl[i].exp_m);
    end
    md = 10;
    mm = 0;

    // Asynchronous reset mid-count at value 2.
    step(1'b1, 1'b1, 8'd2, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_clear_full", val_full, 0);
    chk("async_clear_mod", val_mod, 0);
    md = 0;
    mm = 0;
    en = 1'b1; load = 1'b0; up = 1'b0;
    #1;
    chk("reset_tc_down", tc_full, 1);
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 8'd0, 1'b1);
    chk("after_release_1", val_full, 1);
    step(1'b1, 1'b0, 8'd0, 1'b1);
    chk("after_release_2", val_full, 2);

    // Free run from 0 through a full 256-edge wrap.
    step(1'b1, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      if (md == 255) begin
        en = 1'b1; load = 1'b0; up = 1'b1;
        #1;
        chk("tc_at_255", tc_full, 1);
      end
      step(1'b1, 1'b0, 8'd0, 1'b1);
    end
    chk("free_run_wrap", val_full, 0);

    // Randomised traffic, with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0 && reset_n) begin
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        md = 0;
        mm = 0;
        chk("rand_async_full", val_full, 0);
        chk("rand_async_mod", val_mod, 0);
        @(posedge clk);
        #1;
      end else if (!reset_n && $urandom_range(0, 2) == 0) begin
        reset_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
